// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement, RV32 load/store formatting and one-word-per-ack memory port.
module cache_nway #(
   parameter int WAYS       = 2,
   parameter int SETS       = 32,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_BITS  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [2:0]           cpu_ubhw,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [31:0]          cpu_din,
   output logic                 cpu_ready,
   output logic                 cpu_resp,
   output logic [31:0]          cpu_dout,
   output logic                 cpu_hit,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_dout,
   input  logic [31:0]          mem_din,
   input  logic                 mem_ack,
   output logic [31:0]          hit_cnt,
   output logic [31:0]          miss_cnt,
   output logic [1:0]           dbg_state
);

   localparam int WAY_W = $clog2(WAYS);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int SET_W = $clog2(SETS);
   localparam int TAG_W = ADDR_BITS - 2 - OFF_W - SET_W;
   localparam logic [WAY_W-1:0] AGE_MAX   = WAY_W'(WAYS - 1);
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   req_addr_q;
   logic                   req_we_q;
   logic [2:0]             req_ubhw_q;
   logic [31:0]            req_din_q;
   logic [WAY_W-1:0]       victim_q;
   logic [OFF_W-1:0]       cnt_q;
   logic                   missed_q;
   logic                   resp_q, hit_q;
   logic [31:0]            dout_q, hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0]       tag_mem  [WAYS][SETS];
   logic [31:0]            data_mem [WAYS][SETS][LINE_WORDS];
   logic [SETS-1:0]        valid_q  [WAYS];
   logic [SETS-1:0]        dirty_q  [WAYS];
   logic [WAY_W-1:0]       age_q    [SETS][WAYS];

   logic [TAG_W-1:0]       req_tag;
   logic [SET_W-1:0]       req_set;
   logic [OFF_W-1:0]       req_word;
   logic                   hit;
   logic [WAY_W-1:0]       hit_way, victim;
   logic                   found_free, last_ack;
   logic [31:0]            line_word, load_val, store_word, wdata;
   logic [7:0]             byte_v;
   logic [15:0]            half_v;
   logic [3:0]             be;

   assign req_tag  = req_addr_q[ADDR_BITS-1 -: TAG_W];
   assign req_set  = req_addr_q[2+OFF_W +: SET_W];
   assign req_word = req_addr_q[2 +: OFF_W];
   assign last_ack = mem_ack && (cnt_q == LAST_WORD);

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][req_set] && (tag_mem[w][req_set] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Lowest invalid way wins; otherwise the way whose age is oldest.
   always_comb begin
      found_free = 1'b0;
      victim     = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found_free && !valid_q[w][req_set]) begin
            found_free = 1'b1;
            victim     = WAY_W'(w);
         end
      end
      if (!found_free) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_set][w] == AGE_MAX) victim = WAY_W'(w);
         end
      end
   end

   always_comb begin
      line_word = data_mem[hit_way][req_set][req_word];
      byte_v    = 8'(line_word >> {req_addr_q[1:0], 3'b000});
      half_v    = req_addr_q[1] ? line_word[31:16] : line_word[15:0];
      if (req_ubhw_q[1])      load_val = line_word;
      else if (req_ubhw_q[0]) load_val = {{16{half_v[15] & ~req_ubhw_q[2]}}, half_v};
      else                    load_val = {{24{byte_v[7] & ~req_ubhw_q[2]}}, byte_v};
      if (req_ubhw_q[1]) begin
         be    = 4'hF;
         wdata = req_din_q;
      end else if (req_ubhw_q[0]) begin
         be    = req_addr_q[1] ? 4'b1100 : 4'b0011;
         wdata = {2{req_din_q[15:0]}};
      end else begin
         be    = 4'b0001 << req_addr_q[1:0];
         wdata = {4{req_din_q[7:0]}};
      end
      store_word = line_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) store_word[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_dout = '0;
      case (state_q)
         S_IDLE:   if (cpu_req) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (hit)                                                 state_d = S_IDLE;
            else if (valid_q[victim][req_set] && dirty_q[victim][req_set]) state_d = S_WRITEBACK;
            else                                                     state_d = S_REFILL;
         end
         S_WRITEBACK: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {tag_mem[victim_q][req_set], req_set, cnt_q, 2'b00};
            mem_dout = data_mem[victim_q][req_set][cnt_q];
            if (last_ack) state_d = S_REFILL;
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_set, cnt_q, 2'b00};
            if (last_ack) state_d = S_LOOKUP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         req_addr_q <= '0;
         req_we_q   <= 1'b0;
         req_ubhw_q <= '0;
         req_din_q  <= '0;
         victim_q   <= '0;
         cnt_q      <= '0;
         missed_q   <= 1'b0;
         resp_q     <= 1'b0;
         hit_q      <= 1'b0;
         dout_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
            for (int s = 0; s < SETS; s++) age_q[s][w] <= WAY_W'(w);
         end
      end else begin
         state_q <= state_d;
         resp_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (cpu_req) begin
               req_addr_q <= cpu_addr;
               req_we_q   <= cpu_we;
               req_ubhw_q <= cpu_ubhw;
               req_din_q  <= cpu_din;
               missed_q   <= 1'b0;
            end
            S_LOOKUP: begin
               if (!missed_q) begin
                  if (hit && hit_cnt_q != '1)        hit_cnt_q  <= hit_cnt_q + 32'd1;
                  else if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
               end
               if (hit) begin
                  resp_q <= 1'b1;
                  hit_q  <= !missed_q;
                  dout_q <= req_we_q ? 32'd0 : load_val;
                  if (req_we_q) dirty_q[hit_way][req_set] <= 1'b1;
                  for (int w = 0; w < WAYS; w++) begin
                     if (WAY_W'(w) == hit_way) age_q[req_set][w] <= '0;
                     else if (age_q[req_set][w] < age_q[req_set][hit_way])
                        age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
                  end
               end else begin
                  missed_q <= 1'b1;
                  victim_q <= victim;
                  cnt_q    <= '0;
                  // A clean victim is invalidated before its words are overwritten.
                  if (!(valid_q[victim][req_set] && dirty_q[victim][req_set]))
                     valid_q[victim][req_set] <= 1'b0;
               end
            end
            S_WRITEBACK: if (mem_ack) begin
               cnt_q <= cnt_q + 1'b1;
               if (last_ack) valid_q[victim_q][req_set] <= 1'b0;
            end
            S_REFILL: if (mem_ack) begin
               cnt_q <= cnt_q + 1'b1;
               if (last_ack) begin
                  valid_q[victim_q][req_set] <= 1'b1;
                  dirty_q[victim_q][req_set] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays are not reset; validity guards their contents.
   always_ff @(posedge clk) begin
      if (state_q == S_LOOKUP && hit && req_we_q)
         data_mem[hit_way][req_set][req_word] <= store_word;
      if (state_q == S_REFILL && mem_ack) begin
         data_mem[victim_q][req_set][cnt_q] <= mem_din;
         if (cnt_q == LAST_WORD) tag_mem[victim_q][req_set] <= req_tag;
      end
   end

   assign cpu_ready = (state_q == S_IDLE);
   assign cpu_resp  = resp_q;
   assign cpu_dout  = dout_q;
   assign cpu_hit   = hit_q;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: CPU responses and memory transfers are
// scoreboarded against hand-computed expectations, with a latency-programmable memory.
module tb_cache_nway;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [2:0]  cpu_ubhw = 3'b000;
   logic [31:0] cpu_addr = '0, cpu_din = '0;
   logic        cpu_ready, cpu_resp, cpu_hit;
   logic [31:0] cpu_dout;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_dout;
   logic [31:0] mem_din = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] hit_cnt, miss_cnt;
   logic [1:0]  dbg_state;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   int errors = 0;
   int checks = 0;
   int exp_hits = 0, exp_misses = 0;
   int ack_delay = 0;

   logic [33:0] exp_q[$];      // {check_data, hit, data}
   logic [64:0] exp_mem_q[$];  // {we, addr, data}
   logic [31:0] mem_model [int unsigned];

   always #5 clk = ~clk;

   cache_nway dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ubhw(cpu_ubhw), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_dout(cpu_dout),
      .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_rd_line(input logic [31:0] base);
      for (int i = 0; i < 4; i++) exp_mem_q.push_back({1'b0, base + 32'(4*i), 32'd0});
   endtask

   task automatic exp_wr_line(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
      exp_mem_q.push_back({1'b1, base,         d0});
      exp_mem_q.push_back({1'b1, base + 32'd4,  d1});
      exp_mem_q.push_back({1'b1, base + 32'd8,  d2});
      exp_mem_q.push_back({1'b1, base + 32'd12, d3});
   endtask

   task automatic preload(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
      mem_model[(base >> 2)]     = d0;
      mem_model[(base >> 2) + 1] = d1;
      mem_model[(base >> 2) + 2] = d2;
      mem_model[(base >> 2) + 3] = d3;
   endtask

   // Issue one access from a negedge and wait for its response; returns on the response negedge.
   task automatic access(input logic [31:0] addr, input logic we, input logic [2:0] ubhw,
                         input logic [31:0] din, input logic exp_hit, input logic [31:0] exp_data,
                         input logic noise);
      int t;
      int cyc;
      t = 0;
      while (cpu_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("ready_timeout", 32'(t), 32'd0);
      cpu_req  = 1'b1;
      cpu_we   = we;
      cpu_ubhw = ubhw;
      cpu_addr = addr;
      cpu_din  = din;
      exp_q.push_back({!we, exp_hit, exp_data});
      if (exp_hit) exp_hits++;
      else         exp_misses++;
      @(negedge clk);
      cpu_req = 1'b0;
      cyc = 1;
      while (cpu_resp !== 1'b1 && cyc < 300) begin
         if (noise && cpu_ready === 1'b0) begin
            cpu_req  = 1'b1;
            cpu_addr = 32'h0000_0904;
         end else begin
            cpu_req = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      cpu_req = 1'b0;
      if (cyc >= 300) chk("resp_timeout", 32'(cyc), 32'd0);
      else if (exp_hit) chk("hit_latency", 32'(cyc), 32'd2);
   endtask

   // Response monitor
   always @(negedge clk) begin
      logic [33:0] e;
      if (rst === 1'b1 && cpu_resp === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_hit", 32'(cpu_hit), 32'(e[32]));
            if (e[33]) chk("resp_data", cpu_dout, e[31:0]);
         end
      end
   end

   // Memory responder with programmable ack latency and transfer checking
   logic        busy = 1'b0, stable = 1'b1, s_we = 1'b0;
   logic [31:0] s_addr = '0, s_dout = '0;
   int          wcnt = 0;
   always @(negedge clk) begin
      logic [64:0] e;
      mem_ack = 1'b0;
      if (rst !== 1'b1) begin
         busy = 1'b0;
      end else if (mem_req === 1'b1) begin
         if (!busy) begin
            busy = 1'b1; wcnt = 0; stable = 1'b1;
            s_addr = mem_addr; s_we = mem_we; s_dout = mem_dout;
         end else if (mem_addr !== s_addr || mem_we !== s_we || (s_we && mem_dout !== s_dout)) begin
            stable = 1'b0;
         end
         if (wcnt >= ack_delay) begin
            chk("mem_stable", 32'(stable), 32'd1);
            if (exp_mem_q.size() == 0) begin
               chk("unexpected_mem", mem_addr, 32'hFFFF_FFFF);
            end else begin
               e = exp_mem_q.pop_front();
               chk("mem_we", 32'(mem_we), 32'(e[64]));
               chk("mem_addr", mem_addr, e[63:32]);
               if (e[64]) chk("mem_wdata", mem_dout, e[31:0]);
            end
            if (mem_we) mem_model[mem_addr >> 2] = mem_dout;
            else mem_din = mem_model.exists(mem_addr >> 2) ? mem_model[mem_addr >> 2]
                                                           : (mem_addr ^ 32'hA5A5_0000);
            mem_ack = 1'b1;
            busy = 1'b0;
         end else begin
            wcnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      preload(32'h100, 32'h11, 32'h8000_0022, 32'h33, 32'h44);
      preload(32'h300, 32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003);
      preload(32'h500, 32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003);
      preload(32'h700, 32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003);
      preload(32'hB00, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);

      // Clock/reset
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(cpu_ready), 32'd1);
      chk("rst_resp", 32'(cpu_resp), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Cold miss, then hits with byte formatting
      exp_rd_line(32'h100);
      access(32'h104, 1'b0, LW, 32'd0, 1'b0, 32'h8000_0022, 1'b0);
      chk("miss_cnt_1", miss_cnt, 32'(exp_misses));
      chk("hit_cnt_0", hit_cnt, 32'(exp_hits));
      access(32'h107, 1'b0, LB,  32'd0, 1'b1, 32'hFFFF_FF80, 1'b0);
      access(32'h107, 1'b0, LBU, 32'd0, 1'b1, 32'h0000_0080, 1'b0);
      chk("hit_cnt_2", hit_cnt, 32'(exp_hits));

      // Half store merge and assorted load widths
      access(32'h10A, 1'b1, LH, 32'h1234_BEEF, 1'b1, 32'd0, 1'b0);
      access(32'h108, 1'b0, LW,  32'd0, 1'b1, 32'hBEEF_0033, 1'b0);
      access(32'h10B, 1'b0, LW,  32'd0, 1'b1, 32'hBEEF_0033, 1'b0);
      access(32'h10A, 1'b0, LH,  32'd0, 1'b1, 32'hFFFF_BEEF, 1'b0);
      access(32'h10B, 1'b0, LHU, 32'd0, 1'b1, 32'h0000_BEEF, 1'b0);
      access(32'h108, 1'b0, LH,  32'd0, 1'b1, 32'h0000_0033, 1'b0);
      access(32'h10B, 1'b0, LB,  32'd0, 1'b1, 32'hFFFF_FFBE, 1'b0);
      access(32'h109, 1'b0, LB,  32'd0, 1'b1, 32'h0000_0000, 1'b0);

      // Fill the second way, then evict the dirty LRU line
      exp_rd_line(32'h300);
      access(32'h300, 1'b0, LW, 32'd0, 1'b0, 32'h3000_0000, 1'b0);
      exp_wr_line(32'h100, 32'h11, 32'h8000_0022, 32'hBEEF_0033, 32'h44);
      exp_rd_line(32'h500);
      access(32'h500, 1'b0, LW, 32'd0, 1'b0, 32'h5000_0000, 1'b0);
      access(32'h304, 1'b0, LW, 32'd0, 1'b1, 32'h3000_0001, 1'b0);
      access(32'h502, 1'b1, LB, 32'h0000_005A, 1'b1, 32'd0, 1'b0);
      access(32'h500, 1'b0, LW, 32'd0, 1'b1, 32'h505A_0000, 1'b0);
      access(32'h308, 1'b1, LW, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b0);
      access(32'h308, 1'b0, LW, 32'd0, 1'b1, 32'hCAFE_F00D, 1'b0);
      chk("hit_cnt_mid", hit_cnt, 32'(exp_hits));
      chk("miss_cnt_mid", miss_cnt, 32'(exp_misses));

      // Slow memory with CPU request noise while busy
      ack_delay = 5;
      exp_wr_line(32'h500, 32'h505A_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003);
      exp_rd_line(32'h700);
      access(32'h704, 1'b0, LW, 32'd0, 1'b0, 32'h7000_0001, 1'b1);
      repeat (4) @(negedge clk);
      chk("noise_no_extra", 32'(exp_q.size()), 32'd0);

      // Reset asserted while refill word 2 is outstanding
      ack_delay = 3;
      exp_wr_line(32'h300, 32'h3000_0000, 32'h3000_0001, 32'hCAFE_F00D, 32'h3000_0003);
      exp_rd_line(32'hB00);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_ubhw = LW; cpu_addr = 32'hB04;
      @(negedge clk);
      cpu_req = 1'b0;
      t = 0;
      while (!(mem_req === 1'b1 && mem_addr === 32'hB08) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("refill_w2_timeout", 32'(t), 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
      chk("mid_rst_ready", 32'(cpu_ready), 32'd1);
      chk("mid_rst_state", 32'(dbg_state), 32'd0);
      chk("mid_rst_hit_cnt", hit_cnt, 32'd0);
      chk("mid_rst_miss_cnt", miss_cnt, 32'd0);
      exp_mem_q.delete();
      exp_q.delete();
      exp_hits = 0;
      exp_misses = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      exp_rd_line(32'h100);
      access(32'h104, 1'b0, LW, 32'd0, 1'b0, 32'h8000_0022, 1'b0);
      exp_rd_line(32'h300);
      access(32'h308, 1'b0, LW, 32'd0, 1'b0, 32'hCAFE_F00D, 1'b0);
      access(32'h10A, 1'b0, LHU, 32'd0, 1'b1, 32'h0000_BEEF, 1'b0);
      chk("post_rst_miss_cnt", miss_cnt, 32'(exp_misses));
      chk("post_rst_hit_cnt", hit_cnt, 32'(exp_hits));

      // Final report
      repeat (5) @(negedge clk);
      chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
